// File: rtl/dcache_ctrl_if.sv
// Bus bundles around the L1 data cache: CPU request side and
// line-wide backing-memory side.

interface dcache_cpu_if;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] rdata_o;
    logic        stall_o;

    modport master (
        output addr_i,
        output wdata_i,
        output MemRead_i,
        output MemWrite_i,
        input  rdata_o,
        input  stall_o
    );

    modport slave (
        input  addr_i,
        input  wdata_i,
        input  MemRead_i,
        input  MemWrite_i,
        output rdata_o,
        output stall_o
    );
endinterface

interface dcache_mem_if #(
    parameter int LINE_W = 256
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller.
// Define DCACHE_STATS_EN to add hit_cnt_o / miss_cnt_o counters.

module dcache_ctrl #(
    parameter int INDEX_W = 5,
    parameter int LINE_W  = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 27 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         off;
    logic [7:0]         bit_off;
    logic [LINE_W-1:0]  line;
    logic [31:0]        word;

    logic req;
    logic hit;
    logic idle;
    logic miss;
    logic acc_hit;
    logic store_hit;
    logic fill_we;
    logic unused_ok;

    assign idx     = cpu.addr_i[4+INDEX_W:5];
    assign tag     = cpu.addr_i[31:5+INDEX_W];
    assign off     = cpu.addr_i[4:2];
    assign bit_off = {off, 5'b0};
    assign line    = data_q[idx];
    assign word    = line[bit_off +: 32];

    assign unused_ok = ^cpu.addr_i[1:0];

    assign req  = cpu.MemRead_i | cpu.MemWrite_i;
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign idle = (state_q == IDLE);

    assign miss      = idle && req && !hit;
    assign acc_hit   = idle && req && hit;
    // a simultaneous read+write is treated as a store
    assign store_hit = acc_hit && cpu.MemWrite_i;
    assign fill_we   = (state_q == ALLOCATE) && mem.mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = dirty_q[idx] && valid_q[idx]
                            ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem.mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem.mem_ack_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem.mem_req_o   = 1'b0;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = '0;
        mem.mem_wdata_o = '0;
        // stall drops with reset even if the frozen request is still up
        cpu.stall_o = !rst_i && (!idle || miss);
        cpu.rdata_o = (cpu.MemRead_i && acc_hit) ? word : '0;
        unique case (state_q)
            WRITEBACK: begin
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = 1'b1;
                mem.mem_addr_o  = {tag_q[idx], idx, 5'b0};
                mem.mem_wdata_o = line;
            end
            ALLOCATE: begin
                mem.mem_req_o  = 1'b1;
                mem.mem_addr_o = {cpu.addr_i[31:5], 5'b0};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // tag and data storage carry no reset; valid gates their use
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem.mem_rdata_i;
        end else if (store_hit) begin
            data_q[idx][bit_off +: 32] <= cpu.wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (acc_hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (miss) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: flat-memory reference model,
// randomized loads/stores, memory responder with random latency.

module tb_dcache_ctrl;

    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dcache_cpu_if cpu ();
    dcache_mem_if #(.LINE_W(LW)) mem ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(
        .INDEX_W(5),
        .LINE_W (LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cpu  (cpu),
        .mem  (mem)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o (hit_cnt),
        .miss_cnt_o(miss_cnt)
`endif
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [LW-1:0] line;
    } xfer_t;

    xfer_t       mem_q [$];
    logic [31:0] ld_q  [$];

    int checks = 0;
    int errors = 0;

    // reference state: coherent word view plus cache directory
    logic [31:0]   ref_m [logic [31:0]];
    bit            res_v [32];
    logic [21:0]   res_t [32];
    bit            res_d [32];
    logic [LW-1:0] mem_m [logic [31:0]];

    int n_req  = 0;
    int n_miss = 0;
    int xfer_total = 0;
    int fix_n = -1;
    bit hold = 1'b0;
    int late_ack_cnt = 0;
    int late_done = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] init_line(input logic [31:0] la);
        logic [LW-1:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (la ^ (w << 28) ^ 32'h5EED_0000) + w;
        end
        if (la == 32'h40) begin
            l[31:0] = 32'h1234_5678;
        end
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [LW-1:0] l;
        if (ref_m.exists(a)) begin
            return ref_m[a];
        end
        l = init_line({a[31:5], 5'b0});
        return l[a[4:2]*32 +: 32];
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [31:0] la);
        logic [LW-1:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = ref_word(la + 32'(w * 4));
        end
        return l;
    endfunction

    task automatic model_reset();
        ref_m.delete();
        for (int i = 0; i < 32; i++) begin
            res_v[i] = 1'b0;
            res_d[i] = 1'b0;
            res_t[i] = '0;
        end
        n_req  = 0;
        n_miss = 0;
    endtask

    task automatic issue(input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        logic [4:0]  ix;
        logic [21:0] tg;
        bit          hit;
        int          sc;
        int          base;
        xfer_t       e;
        ix  = a[9:5];
        tg  = a[31:10];
        hit = res_v[ix] && (res_t[ix] == tg);
        if (!hit) begin
            n_miss++;
            if (res_v[ix] && res_d[ix]) begin
                e.we   = 1'b1;
                e.addr = {res_t[ix], ix, 5'b0};
                e.line = ref_line(e.addr);
                mem_q.push_back(e);
            end
            e.we   = 1'b0;
            e.addr = {a[31:5], 5'b0};
            e.line = '0;
            mem_q.push_back(e);
            res_v[ix] = 1'b1;
            res_t[ix] = tg;
            res_d[ix] = 1'b0;
        end
        n_req++;
        if (wr) begin
            ref_m[a] = d;
            res_d[ix] = 1'b1;
        end else begin
            ld_q.push_back(ref_word(a));
        end
        base = xfer_total;
        @(posedge clk);
        #1;
        cpu.addr_i     = a;
        cpu.wdata_i    = d;
        cpu.MemRead_i  = rd;
        cpu.MemWrite_i = wr;
        @(negedge clk);
        chk("hit_stall", LW'(cpu.stall_o), LW'(!hit));
        sc = 0;
        while (cpu.stall_o && sc < 200) begin
            sc++;
            @(negedge clk);
        end
        if (cpu.stall_o) begin
            chk("stall_timeout", LW'(cpu.stall_o), '0);
        end else if (!hit) begin
            chk("miss_stall_len", LW'(sc), LW'(xfer_total - base + 2));
        end
        @(posedge clk);
        #1;
        cpu.MemRead_i  = 1'b0;
        cpu.MemWrite_i = 1'b0;
    endtask

    // memory responder doubles as the transfer monitor
    initial begin
        int    n;
        xfer_t e;
        mem.mem_ack_i   = 1'b0;
        mem.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            mem.mem_ack_i = 1'b0;
            if (late_ack_cnt != late_done) begin
                late_done++;
                mem.mem_rdata_i = {8{32'hBAD0_BAD0}};
                mem.mem_ack_i   = 1'b1;
            end else if (!rst && !hold && mem.mem_req_o) begin
                if (mem_q.size() == 0) begin
                    chk("xfer_unexpected", LW'(1), '0);
                end else begin
                    e = mem_q.pop_front();
                    chk("xfer_we", LW'(mem.mem_we_o), LW'(e.we));
                    chk("xfer_addr", LW'(mem.mem_addr_o), LW'(e.addr));
                    if (e.we) begin
                        chk("wb_line", mem.mem_wdata_o, e.line);
                    end
                end
                n = (fix_n >= 0) ? fix_n : int'($urandom_range(0, 3));
                xfer_total += n + 1;
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
                if (mem.mem_we_o) begin
                    mem_m[mem.mem_addr_o] = mem.mem_wdata_o;
                end else if (mem_m.exists(mem.mem_addr_o)) begin
                    mem.mem_rdata_i = mem_m[mem.mem_addr_o];
                end else begin
                    mem.mem_rdata_i = init_line(mem.mem_addr_o);
                end
                mem.mem_ack_i = 1'b1;
            end
        end
    end

    // load-result monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cpu.MemRead_i && !cpu.MemWrite_i
                && !cpu.stall_o) begin
                if (ld_q.size() == 0) begin
                    chk("ld_unexpected", LW'(1), '0);
                end else begin
                    chk("ld_data", LW'(cpu.rdata_o), LW'(ld_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          w;
        int          op;
        cpu.addr_i     = '0;
        cpu.wdata_i    = '0;
        cpu.MemRead_i  = 1'b0;
        cpu.MemWrite_i = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", LW'(cpu.stall_o), '0);
        chk("rst_req", LW'(mem.mem_req_o), '0);
        chk("rst_we", LW'(mem.mem_we_o), '0);
        chk("rst_addr", LW'(mem.mem_addr_o), '0);
        chk("rst_wdata", mem.mem_wdata_o, '0);
        chk("rst_rdata", LW'(cpu.rdata_o), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset in the middle of a refill
        hold = 1'b1;
        a = 32'h0000_0C40;
        @(posedge clk);
        #1;
        cpu.addr_i    = a;
        cpu.MemRead_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (!mem.mem_req_o && w < 10) begin
            w++;
            @(negedge clk);
        end
        chk("alloc_req", LW'(mem.mem_req_o), LW'(1));
        chk("alloc_we", LW'(mem.mem_we_o), '0);
        chk("alloc_addr", LW'(mem.mem_addr_o), LW'(32'h0000_0C40));
        @(posedge clk);
        #4;
        rst = 1'b1;
        cpu.MemRead_i = 1'b0;
        #1;
        chk("midrst_req", LW'(mem.mem_req_o), '0);
        chk("midrst_stall", LW'(cpu.stall_o), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        late_ack_cnt++;
        repeat (3) @(negedge clk);
        chk("late_ack_req", LW'(mem.mem_req_o), '0);
        chk("late_ack_stall", LW'(cpu.stall_o), '0);
        model_reset();
        hold = 1'b0;
        issue(1'b1, 1'b0, a, '0);

        // cold load, store hit, conflict write-back, store miss merge
        fix_n = 2;
        issue(1'b1, 1'b0, 32'h0000_0040, '0);
        fix_n = -1;
        issue(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 32'h0000_0044, '0);
        issue(1'b1, 1'b0, 32'h0000_0440, '0);
        issue(1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b0, 32'h0000_0080 + 32'(i * 4), '0);
        end
        issue(1'b1, 1'b0, 32'h0000_0480, '0);

        for (int i = 0; i < 250; i++) begin
            a  = 32'($urandom_range(0, 3)) << 10;
            a |= 32'($urandom_range(0, 7)) << 5;
            a |= 32'($urandom_range(0, 7)) << 2;
            op = int'($urandom_range(0, 4));
            if (op < 2) begin
                issue(1'b1, 1'b0, a, '0);
            end else if (op < 4) begin
                issue(1'b0, 1'b1, a, $urandom);
            end else begin
                issue(1'b1, 1'b1, a, $urandom);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        chk("mem_q_empty", LW'(mem_q.size()), '0);
        chk("ld_q_empty", LW'(ld_q.size()), '0);
`ifdef DCACHE_STATS_EN
        chk("hit_cnt", LW'(hit_cnt), LW'(n_req));
        chk("miss_cnt", LW'(miss_cnt), LW'(n_miss));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
